// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding, default
// parameter values and the channel-search helper used by the release phases.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    HOLD         = 3'd0,
    POR_WAIT     = 3'd1,
    RELEASE      = 3'd2,
    RUN          = 3'd3,
    SOFT_HOLD    = 3'd4,
    SOFT_RELEASE = 3'd5
  } state_e;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_CNT_W       = 12;
  localparam int DEF_POR_CYCLES  = 800;
  localparam int DEF_STAGE_GAP   = 16;
  localparam int DEF_SOFT_CYCLES = 32;
  localparam int DEF_SYNC_STAGES = 2;

  // Lowest set bit of mask at or above 'from' and below 'limit';
  // returns 'limit' when no such bit exists.
  function automatic logic [3:0] next_set(input logic [7:0] mask,
                                          input logic [3:0] from,
                                          input logic [3:0] limit);
    logic [3:0] r;
    r = limit;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= from) && (4'(i) < limit)) r = 4'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Asynchronous-assert, synchronous-deassert reset synchronizer.
module reset_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  output logic srst_n
);

  logic [SYNC_STAGES-1:0] ff;

  // Shift ones in after release; any assertion clears the chain at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ff <= '0;
    else          ff <= {ff[SYNC_STAGES-2:0], 1'b1};
  end

  assign srst_n = ff[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged power-on and soft reset sequencer. One shared delay counter and
// one channel index register drive every timed phase; the state register
// is exposed on state_dbg.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int POR_CYCLES  = DEF_POR_CYCLES,
  parameter int STAGE_GAP   = DEF_STAGE_GAP,
  parameter int SOFT_CYCLES = DEF_SOFT_CYCLES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              soft_req,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [NUM_CH-1:0] reset_out,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_dbg
);

  localparam int unsigned MAX_CNT = (32'd1 << CNT_W) - 32'd1;

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("reset_sequencer: NUM_CH must be 1..8");
  end
  if (CNT_W < 10 || CNT_W > 24) begin : g_bad_cnt_w
    $error("reset_sequencer: CNT_W must be 10..24");
  end
  if (POR_CYCLES < 1 || POR_CYCLES > MAX_CNT) begin : g_bad_por
    $error("reset_sequencer: POR_CYCLES out of range");
  end
  if (STAGE_GAP < 1 || STAGE_GAP > MAX_CNT) begin : g_bad_gap
    $error("reset_sequencer: STAGE_GAP out of range");
  end
  if (SOFT_CYCLES < 1 || SOFT_CYCLES > MAX_CNT) begin : g_bad_soft
    $error("reset_sequencer: SOFT_CYCLES out of range");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("reset_sequencer: SYNC_STAGES must be 2..4");
  end

  // Terminal counts. POR_WAIT is entered one edge after T0 with the counter
  // preloaded to 1, so its terminal value is POR_CYCLES-1. A POR_CYCLES of 1
  // releases at T0+2, the earliest edge the FSM can act on.
  localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_CYCLES - 1);
  localparam logic [3:0]       NCH       = 4'(NUM_CH);

  state_e              state;
  logic [CNT_W-1:0]    cnt;
  logic [3:0]          idx;
  logic [NUM_CH-1:0]   mask_q;
  logic                soft_q;
  logic                srst_n;
  logic                soft_go;
  logic [7:0]          mask_w;
  logic [3:0]          nxt_ch;
  logic [NUM_CH-1:0]   nxt_bit;

  reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .srst_n  (srst_n)
  );

  // Edge-qualified soft request and the next latched channel to release.
  always_comb begin
    soft_go                = soft_req & ~soft_q & (|ch_mask);
    mask_w                 = '0;
    mask_w[NUM_CH-1:0]     = mask_q;
    nxt_ch                 = next_set(mask_w, idx, NCH);
    nxt_bit                = NUM_CH'(1) << nxt_ch;
  end

  // Sequencer state, shared counter, channel index and reset outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= HOLD;
      reset_out <= '1;
      cnt       <= '0;
      idx       <= '0;
      mask_q    <= '0;
      soft_q    <= 1'b0;
    end else begin
      soft_q <= soft_req;
      case (state)
        HOLD: begin
          reset_out <= '1;
          idx       <= '0;
          cnt       <= '0;
          if (srst_n) begin
            state <= POR_WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        POR_WAIT: begin
          if (cnt >= POR_LAST) begin
            reset_out <= reset_out & ~NUM_CH'(1);
            idx       <= 4'd1;
            cnt       <= '0;
            state     <= RELEASE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (idx == NCH) begin
            cnt   <= '0;
            state <= RUN;
          end else if (cnt == GAP_LAST) begin
            reset_out <= reset_out & ~(NUM_CH'(1) << idx);
            idx       <= idx + 4'd1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RUN: begin
          cnt       <= '0;
          reset_out <= '0;
          if (soft_go) begin
            mask_q    <= ch_mask;
            reset_out <= ch_mask;
            idx       <= '0;
            state     <= SOFT_HOLD;
          end
        end
        SOFT_HOLD: begin
          if (cnt == SOFT_LAST) begin
            reset_out <= reset_out & ~nxt_bit;
            idx       <= nxt_ch + 4'd1;
            cnt       <= '0;
            state     <= SOFT_RELEASE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SOFT_RELEASE: begin
          if (nxt_ch == NCH) begin
            cnt   <= '0;
            state <= RUN;
          end else if (cnt == GAP_LAST) begin
            reset_out <= reset_out & ~nxt_bit;
            idx       <= nxt_ch + 4'd1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

  assign done      = (state == RUN);
  assign busy      = (state != RUN);
  assign state_dbg = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer with the default parameters.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int NUM_CH = 4;
  localparam int POR    = 800;
  localparam int GAP    = 16;
  localparam int SOFT   = 32;
  localparam int SYNC   = 2;

  logic              clock;
  logic              reset_n;
  logic              soft_req;
  logic [NUM_CH-1:0] ch_mask;
  logic [NUM_CH-1:0] reset_out;
  logic              busy;
  logic              done;
  logic [2:0]        state_dbg;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;

  reset_sequencer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .soft_req  (soft_req),
    .ch_mask   (ch_mask),
    .reset_out (reset_out),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock and edge counter.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Reference: {done, reset_out} after edge e, where reset_n rose just after edge 0.
  function automatic logic [NUM_CH:0] por_exp(int e);
    logic [NUM_CH:0] r;
    r = '0;
    for (int k = 0; k < NUM_CH; k++) r[k] = (e < SYNC + POR + k * GAP);
    r[NUM_CH] = (e >= SYNC + POR + (NUM_CH - 1) * GAP + 1);
    return r;
  endfunction

  // Reference: {done, reset_out} d edges after edge E, where a soft request
  // with mask m was raised just after edge E (so it is sampled at E+1).
  function automatic logic [NUM_CH:0] soft_exp(logic [NUM_CH-1:0] m, int d);
    logic [NUM_CH:0] r;
    int rank;
    int rel;
    int last;
    r    = '0;
    rank = 0;
    last = -1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (m[k]) begin
        rel  = 1 + SOFT + rank * GAP;
        r[k] = (d >= 1) && (d < rel);
        last = rel;
        rank++;
      end
    end
    r[NUM_CH] = (d < 1) || (d >= last + 1);
    return r;
  endfunction

  task automatic test_reset();
    reset_n  = 1'b0;
    soft_req = 1'b0;
    ch_mask  = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp++; if (reset_out !== '1) begin n_bad++; $display("FAIL reset_out_in_reset: got %b expected 1111", reset_out); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_in_reset: got %b expected 1", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_in_reset: got %b expected 0", done); end
    n_cmp++; if (state_dbg !== 3'(HOLD)) begin n_bad++; $display("FAIL state_in_reset: got %0d expected %0d", state_dbg, HOLD); end
  endtask

  // Power-on sequence with random soft requests thrown in during POR_WAIT.
  task automatic test_power_on();
    int base;
    int e;
    logic [NUM_CH:0] ex;
    @(posedge clock);
    #1 reset_n = 1'b1;
    base = cyc;
    for (int i = 0; i < 870; i++) begin
      @(negedge clock);
      e  = cyc - base;
      ex = por_exp(e);
      n_cmp++; if (reset_out !== ex[NUM_CH-1:0]) begin n_bad++; $display("FAIL por_reset_out e=%0d: got %b expected %b", e, reset_out, ex[NUM_CH-1:0]); end
      n_cmp++; if (done !== ex[NUM_CH]) begin n_bad++; $display("FAIL por_done e=%0d: got %b expected %b", e, done, ex[NUM_CH]); end
      n_cmp++; if (busy !== !ex[NUM_CH]) begin n_bad++; $display("FAIL por_busy e=%0d: got %b expected %b", e, busy, !ex[NUM_CH]); end
      if (e >= 100 && e < 700) begin
        soft_req = 1'($urandom_range(0, 1));
        ch_mask  = NUM_CH'($urandom_range(1, 15));
      end else begin
        soft_req = 1'b0;
      end
    end
    n_cmp++; if (state_dbg !== 3'(RUN)) begin n_bad++; $display("FAIL por_final_state: got %0d expected %0d", state_dbg, RUN); end
  endtask

  // Directed 1010 request; the mask input is changed during the hold.
  task automatic test_soft_mask_change();
    int base;
    int d;
    logic [NUM_CH:0] ex;
    @(posedge clock);
    #1 soft_req = 1'b1;
    ch_mask = 4'b1010;
    base = cyc;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      d  = cyc - base;
      ex = soft_exp(4'b1010, d);
      n_cmp++; if (reset_out !== ex[NUM_CH-1:0]) begin n_bad++; $display("FAIL soft1010_reset_out d=%0d: got %b expected %b", d, reset_out, ex[NUM_CH-1:0]); end
      n_cmp++; if (done !== ex[NUM_CH]) begin n_bad++; $display("FAIL soft1010_done d=%0d: got %b expected %b", d, done, ex[NUM_CH]); end
      n_cmp++; if (busy !== !ex[NUM_CH]) begin n_bad++; $display("FAIL soft1010_busy d=%0d: got %b expected %b", d, busy, !ex[NUM_CH]); end
      if (d >= 1) soft_req = 1'b0;
      if (d == 10) ch_mask = 4'b0101;
    end
  endtask

  // Random nonzero masks with random idle gaps and a scrambled mask input.
  task automatic test_soft_random();
    int base;
    int d;
    int idle;
    logic [NUM_CH-1:0] m;
    logic [NUM_CH:0] ex;
    for (int it = 0; it < 6; it++) begin
      m    = NUM_CH'($urandom_range(1, 15));
      idle = $urandom_range(1, 8);
      for (int j = 0; j < idle; j++) begin
        @(negedge clock);
        n_cmp++; if ({done, reset_out} !== {1'b1, {NUM_CH{1'b0}}}) begin n_bad++; $display("FAIL idle_run: got %b expected 10000", {done, reset_out}); end
      end
      @(posedge clock);
      #1 soft_req = 1'b1;
      ch_mask = m;
      base = cyc;
      for (int i = 0; i < 1 + SOFT + (NUM_CH - 1) * GAP + 4; i++) begin
        @(negedge clock);
        d  = cyc - base;
        ex = soft_exp(m, d);
        n_cmp++; if (reset_out !== ex[NUM_CH-1:0]) begin n_bad++; $display("FAIL softrnd_reset_out m=%b d=%0d: got %b expected %b", m, d, reset_out, ex[NUM_CH-1:0]); end
        n_cmp++; if (done !== ex[NUM_CH]) begin n_bad++; $display("FAIL softrnd_done m=%b d=%0d: got %b expected %b", m, d, done, ex[NUM_CH]); end
        if (d >= 1) begin
          soft_req = 1'b0;
          ch_mask  = NUM_CH'($urandom_range(0, 15));
        end
      end
    end
  endtask

  // Request with an empty mask must leave the block idle in RUN.
  task automatic test_ignored();
    @(posedge clock);
    #1 soft_req = 1'b1;
    ch_mask = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      soft_req = 1'b0;
      n_cmp++; if ({busy, done, reset_out} !== {2'b01, {NUM_CH{1'b0}}}) begin n_bad++; $display("FAIL ignored_zero_mask i=%0d: got %b expected 010000", i, {busy, done, reset_out}); end
    end
  endtask

  // soft_req held high for 200 cycles gives exactly one sequence.
  task automatic test_level_hold();
    int base;
    int d;
    logic [NUM_CH-1:0] m;
    logic [NUM_CH:0] ex;
    m = NUM_CH'($urandom_range(1, 15));
    @(posedge clock);
    #1 soft_req = 1'b1;
    ch_mask = m;
    base = cyc;
    for (int i = 0; i < 215; i++) begin
      @(negedge clock);
      d  = cyc - base;
      ex = soft_exp(m, d);
      n_cmp++; if ({done, reset_out} !== ex) begin n_bad++; $display("FAIL level_hold m=%b d=%0d: got %b expected %b", m, d, {done, reset_out}, ex); end
      if (d >= 200) soft_req = 1'b0;
    end
  endtask

  // Reset asserted at edge 810 of a power-on, then a full restart.
  task automatic test_mid_reset();
    int base;
    int e;
    logic [NUM_CH:0] ex;
    @(posedge clock);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    base = cyc;
    for (int i = 0; i < 810; i++) begin
      @(negedge clock);
      e  = cyc - base;
      ex = por_exp(e);
      n_cmp++; if ({done, reset_out} !== ex) begin n_bad++; $display("FAIL mid_pre e=%0d: got %b expected %b", e, {done, reset_out}, ex); end
    end
    @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    n_cmp++; if (reset_out !== '1) begin n_bad++; $display("FAIL mid_async_reset_out: got %b expected 1111", reset_out); end
    n_cmp++; if ({busy, done} !== 2'b10) begin n_bad++; $display("FAIL mid_async_busy_done: got %b expected 10", {busy, done}); end
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    base = cyc;
    for (int i = 0; i < 860; i++) begin
      @(negedge clock);
      e  = cyc - base;
      ex = por_exp(e);
      n_cmp++; if ({done, reset_out} !== ex) begin n_bad++; $display("FAIL mid_restart e=%0d: got %b expected %b", e, {done, reset_out}, ex); end
      n_cmp++; if (busy !== !ex[NUM_CH]) begin n_bad++; $display("FAIL mid_restart_busy e=%0d: got %b expected %b", e, busy, !ex[NUM_CH]); end
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_soft_mask_change();
    test_soft_random();
    test_ignored();
    test_level_hold();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent reset output channels, legal 1..8.
REQ-002 Parameter CNT_W, default 12: width of the shared delay counter, legal 10..24.
REQ-003 Parameter POR_CYCLES, default 800: power-on hold length in clocks; legal 1..2^CNT_W-1.
REQ-004 Parameter STAGE_GAP, default 16: clocks between successive channel releases; legal 1..2^CNT_W-1.
REQ-005 Parameter SOFT_CYCLES, default 32: soft-reset hold length in clocks; legal 1..2^CNT_W-1.
REQ-006 Parameter SYNC_STAGES, default 2: depth of the reset-release synchronizer, legal 2..4.
REQ-007 clock  input  1  sole clock, all state on rising edge.
REQ-008 reset_n  input  1  asynchronous, active-low block reset.
REQ-009 soft_req  input  1  synchronous soft-reset request; rising edge is a request.
REQ-010 ch_mask  input  NUM_CH  channels affected by a soft reset; bit k selects channel k.
REQ-011 reset_out  output  NUM_CH  active-high per-channel reset; bit k drives channel k.
REQ-012 busy  output  1  high while any hold or staged release is in progress.
REQ-013 done  output  1  high when all channels are released and the block is idle in RUN.

Function
REQ-014 FSM states: HOLD, POR_WAIT, RELEASE, RUN, SOFT_HOLD, SOFT_RELEASE.
REQ-015 HOLD: all reset_out=1, busy=1, done=0; exit to POR_WAIT on the first edge where the synchronized release (srst_n) is 1.
REQ-016 srst_n rises at the SYNC_STAGES-th rising edge after reset_n deasserts; call that edge T0.
REQ-017 POR_WAIT counts POR_CYCLES clocks; reset_out[0] falls at edge T0+POR_CYCLES.
REQ-018 RELEASE: channel k falls at edge T0+POR_CYCLES+k*STAGE_GAP, in ascending order, one channel per step.
REQ-019 done rises and busy falls one edge after the last channel release, entering RUN.
REQ-020 RUN: reset_out all 0, done=1, busy=0, counter held at 0.
REQ-021 soft_req rising edge is detected with a one-flop edge detector; level-high soft_req does not retrigger.
REQ-022 A soft request in RUN with ch_mask!=0 is accepted: ch_mask is latched, done=0, busy=1, and the masked channels' reset_out go to 1 on the next edge, entering SOFT_HOLD.
REQ-023 A soft request with ch_mask==0 is ignored; there is no state change.
REQ-024 Soft requests arriving outside RUN are dropped, not queued.
REQ-025 SOFT_HOLD lasts SOFT_CYCLES clocks, then SOFT_RELEASE frees the latched channels in ascending index order, STAGE_GAP apart; the first is released on the edge ending SOFT_HOLD.
REQ-026 Unmasked channels remain 0 throughout a soft sequence, and masked-off indices consume no gap.
REQ-027 After the last latched channel is released, done rises one edge later, returning to RUN.
REQ-028 ch_mask changes after latching have no effect on the sequence in progress.
REQ-029 The counter never wraps; each phase ends on terminal-count compare, then the counter is cleared.

Reset
REQ-030 reset_n low asynchronously forces: state HOLD, reset_out all 1, busy=1, done=0, counter 0, latched mask 0, edge-detect flop 0, synchronizer flops 0.
REQ-031 reset_n asserted in any state, including mid POR_WAIT, RELEASE or soft sequence, aborts that state; the full power-on sequence restarts from REQ-015 after release.
REQ-032 Deassertion is only observed through the SYNC_STAGES synchronizer; no output changes in the same cycle as reset_n rises.

Structure
REQ-033 Package reset_seq_pkg holds the state enum and the default parameter constants.
REQ-034 Sub-module reset_sync implements the async-assert/sync-deassert synchronizer (parameter SYNC_STAGES).
REQ-035 One shared CNT_W counter and one channel index register serve all phases.
REQ-036 Out-of-range parameters are rejected at elaboration.

Verification (NUM_CH=4, POR_CYCLES=800, STAGE_GAP=16, SOFT_CYCLES=32, SYNC_STAGES=2)
REQ-037 Power-on: release reset_n at edge 0 -> T0=edge 2; reset_out bits fall at edges 802/818/834/850; done=1 at 851.
REQ-038 Soft reset: in RUN, pulse soft_req with ch_mask=4'b1010 at edge E -> bits 1 and 3 high from E+1, bit 1 falls E+33, bit 3 falls E+49, done at E+50; bits 0 and 2 stay 0.
REQ-039 Ignored requests: soft_req with ch_mask=0 in RUN -> no change; soft_req during POR_WAIT -> dropped, done still at 851.
REQ-040 Mid-sequence reset: assert reset_n at edge 810 -> all reset_out=1 immediately; on re-release, the timing of REQ-037 repeats relative to the new T0.
REQ-041 Level hold: soft_req held high for 200 cycles -> exactly one soft sequence occurs.
REQ-042 Mask change: alter ch_mask during SOFT_HOLD -> the release pattern follows the originally latched mask.
